// File: rtl/ppu_pkg.sv
// Shared constants, FSM encoding and address helpers for the PPU background fetcher.
package ppu_pkg;

  localparam logic [13:0] NT_BASE   = 14'h2000;
  localparam logic [9:0]  AT_OFFSET = 10'h3C0;
  localparam logic [13:0] PH_OFFSET = 14'h0008;

  // *_A cycles present a new address; *_D cycles hold it and capture the read byte.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_NT_A,
    ST_NT_D,
    ST_AT_A,
    ST_AT_D,
    ST_PL_A,
    ST_PL_D,
    ST_PH_A,
    ST_PH_D
  } fetch_state_t;

  // Nametable byte address: $2000 | nt<<10 | cy<<5 | cx.
  function automatic logic [13:0] nt_addr(input logic [1:0] nt,
                                          input logic [4:0] cy,
                                          input logic [4:0] cx);
    return NT_BASE | {2'b00, nt, 10'h000} | {4'h0, cy, 5'h00} | {9'h000, cx};
  endfunction

  // Attribute byte address: one byte per 4x4 tile block, at the tail of each nametable.
  function automatic logic [13:0] at_addr(input logic [1:0] nt,
                                          input logic [4:0] cy,
                                          input logic [4:0] cx);
    return NT_BASE | {4'h0, AT_OFFSET} | {2'b00, nt, 10'h000}
         | {8'h00, cy[4:2], 3'b000} | {11'h000, cx[4:2]};
  endfunction

  // Pattern plane 0 address: pt<<12 | tile<<4 | fy (plane 1 adds PH_OFFSET).
  function automatic logic [13:0] pl_addr(input logic       pt,
                                          input logic [7:0] tile,
                                          input logic [2:0] fy);
    return {1'b0, pt, tile, 1'b0, fy};
  endfunction

endpackage

// File: rtl/ppu_attribute_select.sv
// Picks the 2-bit palette for one tile out of an attribute byte (four 2x2-tile quadrants).
module ppu_attribute_select (
  input  logic [7:0] attr,
  input  logic       cx_bit1,
  input  logic       cy_bit1,
  output logic [1:0] palette
);

  logic [7:0] shifted;

  // Quadrant shift: bottom half adds 4, right half adds 2.
  always_comb begin
    shifted = attr >> {cy_bit1, cx_bit1, 1'b0};
    palette = shifted[1:0];
  end

endmodule

// File: rtl/ppu_background_fetch.sv
// Background tile fetcher: four PPU reads per tile (NT, AT, PL, PH), one tile every 8 clocks.
module ppu_background_fetch
  import ppu_pkg::*;
#(
  parameter int TILES_PER_LINE = 34
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_fetch_en,
  input  logic [4:0]  i_coarse_x,
  input  logic [4:0]  i_coarse_y,
  input  logic [2:0]  i_fine_y,
  input  logic [1:0]  i_nt_sel,
  input  logic        i_pt_sel,
  output logic [13:0] o_address_ppu,
  output logic        o_rd_en_ppu_n,
  output logic        o_wr_en_ppu_n,
  input  logic [7:0]  i_data_ppu,
  output logic        o_tile_valid,
  output logic [7:0]  o_pattern_lo,
  output logic [7:0]  o_pattern_hi,
  output logic [1:0]  o_palette,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CNT_W = $clog2(TILES_PER_LINE + 1);

  fetch_state_t     state, state_nx;
  logic [4:0]       cx, cy, cx_nx;
  logic [2:0]       fy;
  logic [1:0]       nt, nt_nx;
  logic [7:0]       tile_id_p1;
  logic [7:0]       pat_lo_p1;
  logic [1:0]       pal_p1, pal_sel;
  logic [CNT_W-1:0] tile_cnt;
  logic [13:0]      addr_nx;
  logic             start_ok, last_tile, tile_done;

  assign o_wr_en_ppu_n = 1'b1;

  ppu_attribute_select u_attr_sel (
    .attr    (i_data_ppu),
    .cx_bit1 (cx[1]),
    .cy_bit1 (cy[1]),
    .palette (pal_sel)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next state and the address to present in the next cycle; dropping fetch_en aborts.
  always_comb begin
    state_nx  = state;
    addr_nx   = o_address_ppu;
    start_ok  = 1'b0;
    last_tile = (tile_cnt == CNT_W'(TILES_PER_LINE - 1));
    tile_done = (state == ST_PH_D) && i_fetch_en;
    cx_nx     = cx + 5'd1;
    nt_nx     = (cx == 5'd31) ? (nt ^ 2'b01) : nt;
    if (state != ST_IDLE && !i_fetch_en) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start && i_fetch_en) begin
            state_nx = ST_NT_A;
            start_ok = 1'b1;
            addr_nx  = nt_addr(i_nt_sel, i_coarse_y, i_coarse_x);
          end
        end
        ST_NT_A: state_nx = ST_NT_D;
        ST_NT_D: begin
          state_nx = ST_AT_A;
          addr_nx  = at_addr(nt, cy, cx);
        end
        ST_AT_A: state_nx = ST_AT_D;
        ST_AT_D: begin
          state_nx = ST_PL_A;
          addr_nx  = pl_addr(i_pt_sel, tile_id_p1, fy);
        end
        ST_PL_A: state_nx = ST_PL_D;
        ST_PL_D: begin
          state_nx = ST_PH_A;
          addr_nx  = o_address_ppu | PH_OFFSET;
        end
        ST_PH_A: state_nx = ST_PH_D;
        ST_PH_D: begin
          if (last_tile) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_NT_A;
            addr_nx  = nt_addr(nt_nx, cy, cx_nx);
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Registered bus strobes, status, tile counter and completed-tile outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_address_ppu <= '0;
      o_rd_en_ppu_n <= 1'b1;
      o_tile_valid  <= 1'b0;
      o_pattern_lo  <= '0;
      o_pattern_hi  <= '0;
      o_palette     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      tile_cnt      <= '0;
    end else begin
      o_address_ppu <= addr_nx;
      o_rd_en_ppu_n <= (state_nx == ST_IDLE);
      o_busy        <= (state_nx != ST_IDLE);
      o_tile_valid  <= 1'b0;
      o_done        <= 1'b0;
      if (start_ok) tile_cnt <= '0;
      if (tile_done) begin
        o_pattern_lo <= pat_lo_p1;
        o_pattern_hi <= i_data_ppu;
        o_palette    <= pal_p1;
        o_tile_valid <= 1'b1;
        o_done       <= last_tile;
        tile_cnt     <= tile_cnt + CNT_W'(1);
      end
    end
  end

  // Run coordinates and per-tile read captures (data path, no reset needed).
  always_ff @(posedge i_clk) begin
    if (start_ok) begin
      cx <= i_coarse_x;
      cy <= i_coarse_y;
      fy <= i_fine_y;
      nt <= i_nt_sel;
    end else if (tile_done) begin
      cx <= cx_nx;
      nt <= nt_nx;
    end
    if (state == ST_NT_D) tile_id_p1 <= i_data_ppu;
    if (state == ST_AT_D) pal_p1     <= pal_sel;
    if (state == ST_PL_D) pat_lo_p1  <= i_data_ppu;
  end

endmodule
